// File: rtl/ln_lut_arbiter_if.sv
// Requester-side bundle for ln_lut_arbiter: request handshake, result handshake and
// per-lane busy flags, lane i occupying bits [i*WIDTH +: WIDTH] of the data buses.
interface ln_lut_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_x;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ*WIDTH-1:0] rsp_ln;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [NUM_REQ-1:0]       busy;

    modport master (
        output req_valid, req_x, rsp_ready,
        input  req_ready, rsp_valid, rsp_ln, busy
    );

    modport slave (
        input  req_valid, req_x, rsp_ready,
        output req_ready, rsp_valid, rsp_ln, busy
    );
endinterface

// File: rtl/ln_lut_arbiter.sv
// Round-robin sharing of one registered ln(x) LUT between NUM_REQ requesters; a tag
// pipeline matched to LUT latency routes each result into its requester's one-entry buffer.
module ln_lut_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int LUT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    ln_lut_arbiter_if.slave  req_if,
    output logic             lut_valid_in,
    output logic [WIDTH-1:0] lut_x,
    input  logic             lut_valid_out,
    input  logic [WIDTH-1:0] lut_ln,
    output logic             err_tag
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int GD_W = $clog2(LUT_LAT + 2);

    logic [ID_W-1:0]          r_rr;
    logic [NUM_REQ-1:0]       r_busy;
    logic [NUM_REQ-1:0]       r_rsp_valid;
    logic [NUM_REQ*WIDTH-1:0] r_buf;
    logic [LUT_LAT:0]         r_tag_v;
    logic [ID_W-1:0]          r_tag_id [LUT_LAT+1];
    logic [GD_W-1:0]          r_guard;
    logic                     r_lut_valid_in;
    logic [WIDTH-1:0]         r_lut_x;
    logic                     r_err_tag;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_drain;
    logic [NUM_REQ-1:0] w_fill;
    logic               w_any;
    logic [ID_W-1:0]    w_win;
    logic [ID_W-1:0]    w_rr_next;

    // Registered busy keeps a lane ineligible on the edge its result is drained.
    assign w_elig  = req_if.req_valid & ~r_busy;
    assign w_drain = r_rsp_valid & req_if.rsp_ready;

    always_comb begin
        int unsigned idx;
        idx   = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (off + int'(r_rr)) % NUM_REQ;
            if (!w_any && w_elig[ID_W'(idx)]) begin
                w_any = 1'b1;
                w_win = ID_W'(idx);
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_any) w_grant[w_win] = 1'b1;
    end

    always_comb begin
        w_fill = '0;
        if (r_tag_v[LUT_LAT]) w_fill[r_tag_id[LUT_LAT]] = 1'b1;
    end

    assign w_rr_next = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr           <= '0;
            r_busy         <= '0;
            r_rsp_valid    <= '0;
            r_buf          <= '0;
            r_tag_v        <= '0;
            for (int unsigned s = 0; s <= LUT_LAT; s++) r_tag_id[s] <= '0;
            r_guard        <= GD_W'(LUT_LAT + 1);
            r_lut_valid_in <= 1'b0;
            r_lut_x        <= '0;
            r_err_tag      <= 1'b0;
        end else begin
            r_lut_valid_in <= w_any;
            r_tag_v        <= {r_tag_v[LUT_LAT-1:0], w_any};
            r_tag_id[0]    <= w_win;
            for (int unsigned s = 1; s <= LUT_LAT; s++) r_tag_id[s] <= r_tag_id[s-1];
            if (w_any) begin
                r_rr    <= w_rr_next;
                r_lut_x <= req_if.req_x[w_win*WIDTH +: WIDTH];
            end
            r_busy      <= (r_busy & ~w_drain) | w_grant;
            r_rsp_valid <= (r_rsp_valid & ~w_drain) | w_fill;
            if (r_tag_v[LUT_LAT]) r_buf[r_tag_id[LUT_LAT]*WIDTH +: WIDTH] <= lut_ln;
            // LUT outputs launched before reset still drain out; mask them from the tag check.
            if (r_guard != '0) r_guard <= r_guard - 1'b1;
            else if (lut_valid_out != r_tag_v[LUT_LAT]) r_err_tag <= 1'b1;
        end
    end

    assign req_if.req_ready = w_grant;
    assign req_if.rsp_valid = r_rsp_valid;
    assign req_if.rsp_ln    = r_buf;
    assign req_if.busy      = r_busy;
    assign lut_valid_in     = r_lut_valid_in;
    assign lut_x            = r_lut_x;
    assign err_tag          = r_err_tag;
endmodule

// File: tb/tb_ln_lut_arbiter.sv
// Directed scoreboard bench for ln_lut_arbiter; the LUT is modelled as a 1-cycle
// registered stage returning ~x, and a monitor checks every drained result.
`timescale 1ns/1ps
module tb_ln_lut_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         lut_valid_in;
    logic [W-1:0] lut_x;
    logic         lut_valid_out;
    logic [W-1:0] lut_ln;
    logic         err_tag;
    logic         inj;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q [N][$];
    logic [N-1:0] t3_tab [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0001, 4'b0010, 4'b0000, 4'b1000,
                                  4'b0001, 4'b0010, 4'b0000, 4'b1000,
                                  4'b0001, 4'b0010, 4'b0000, 4'b0100};

    always #5 clk = ~clk;

    ln_lut_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    ln_lut_arbiter #(.NUM_REQ(N), .WIDTH(W), .LUT_LAT(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_if        (bus),
        .lut_valid_in  (lut_valid_in),
        .lut_x         (lut_x),
        .lut_valid_out (lut_valid_out),
        .lut_ln        (lut_ln),
        .err_tag       (err_tag)
    );

    // LUT model: one registered stage, ln := ~x; inj forces a tagless valid
    always @(posedge clk) begin
        lut_valid_out <= lut_valid_in | inj;
        lut_ln        <= ~lut_x;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic do_reset(input int edges);
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        for (int q = 0; q < N; q++) exp_q[q].delete();
        repeat (edges) to_pos();
        rst_n = 1'b1;
    endtask

    task automatic check_grant(input string name, input logic [N-1:0] g);
        chk(name, bus.req_ready, g);
        for (int l = 0; l < N; l++)
            if (g[l]) exp_q[l].push_back(~bus.req_x[l*W +: W]);
    endtask

    task automatic wait_idle(input string name);
        int k;
        int left;
        k    = 0;
        left = 0;
        to_neg();
        while ((bus.busy != '0 || bus.rsp_valid != '0) && k < 30) begin
            to_pos();
            to_neg();
            k++;
        end
        for (int l = 0; l < N; l++) left += exp_q[l].size();
        chk({name, "_busy"}, bus.busy, 64'd0);
        chk({name, "_pending"}, 64'(left), 64'd0);
        to_pos();
    endtask

    // Scoreboard monitor: every result handshake pops that lane's expectation
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                for (int l = 0; l < N; l++) begin
                    if (bus.rsp_valid[l] && bus.rsp_ready[l]) begin
                        if (exp_q[l].size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL rsp_lane%0d: got 0x%08h, expected no response",
                                     l, bus.rsp_ln[l*W +: W]);
                        end else begin
                            chk($sformatf("rsp_lane%0d", l), bus.rsp_ln[l*W +: W],
                                exp_q[l].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.rsp_ready = '0;
        inj           = 1'b0;

        // reset state
        do_reset(2);
        to_neg();
        chk("rst_req_ready", bus.req_ready, 64'd0);
        chk("rst_rsp_valid", bus.rsp_valid, 64'd0);
        chk("rst_busy", bus.busy, 64'd0);
        chk("rst_lut_valid_in", lut_valid_in, 64'd0);
        chk("rst_lut_x", lut_x, 64'd0);
        chk("rst_err_tag", err_tag, 64'd0);
        to_pos();

        // single request, lane 0
        bus.req_valid = 4'b0001;
        bus.req_x[0 +: W] = 32'h0000_8000;
        to_neg();
        check_grant("t1_grant", 4'b0001);
        to_pos();
        bus.req_valid = '0;
        to_neg();
        chk("t1_lut_valid_in", lut_valid_in, 64'd1);
        chk("t1_lut_x", lut_x, 64'h8000);
        chk("t1_busy", bus.busy, 64'b0001);
        chk("t1_rsp_early", bus.rsp_valid, 64'd0);
        to_pos();
        to_neg();
        chk("t1_rsp_edge1", bus.rsp_valid, 64'd0);
        to_pos();
        to_neg();
        chk("t1_rsp_edge2", bus.rsp_valid, 64'b0001);
        chk("t1_rsp_ln", bus.rsp_ln[0 +: W], 64'hFFFF_7FFF);
        to_pos();
        bus.rsp_ready = 4'b0001;
        to_neg();
        to_pos();
        bus.rsp_ready = '0;
        to_neg();
        chk("t1_busy_after", bus.busy, 64'd0);
        chk("t1_rsp_after", bus.rsp_valid, 64'd0);
        to_pos();

        // all lanes requesting, results drained immediately
        do_reset(2);
        bus.rsp_ready = '1;
        bus.req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            for (int l = 0; l < N; l++)
                bus.req_x[l*W +: W] = 32'h1000_0000 * 32'(l + 1) + 32'(c);
            to_neg();
            check_grant($sformatf("t2_grant_c%0d", c), 4'b0001 << (c % 4));
            to_pos();
        end
        bus.req_valid = '0;
        wait_idle("t2");

        // lane 2 withholds rsp_ready
        bus.req_valid = '1;
        for (int l = 0; l < N; l++)
            bus.req_x[l*W +: W] = 32'h0001_0123 + 32'h0001_0000 * 32'(l);
        for (int d = 0; d < 16; d++) begin
            bus.rsp_ready = (d >= 14) ? 4'b1111 : 4'b1011;
            to_neg();
            check_grant($sformatf("t3_grant_d%0d", d), t3_tab[d]);
            if (d >= 5 && d <= 13) begin
                chk("t3_hold_valid", bus.rsp_valid[2], 64'd1);
                chk("t3_hold_ln", bus.rsp_ln[2*W +: W], 64'hFFFC_FEDC);
            end
            to_pos();
        end
        bus.req_valid = '0;
        wait_idle("t3");

        // steer rr to 2, then lanes 0 and 3 compete
        bus.req_valid = 4'b0010;
        bus.req_x[1*W +: W] = 32'h0000_0042;
        to_neg();
        check_grant("t4_setup", 4'b0010);
        to_pos();
        bus.req_valid = '0;
        wait_idle("t4a");
        bus.req_valid = 4'b1001;
        bus.req_x[0*W +: W] = 32'h1234_5678;
        bus.req_x[3*W +: W] = 32'h0F0F_0F0F;
        to_neg();
        check_grant("t4_first", 4'b1000);
        to_pos();
        to_neg();
        check_grant("t4_second", 4'b0001);
        to_pos();
        bus.req_valid = '0;
        wait_idle("t4b");

        // reset with three requests in flight
        bus.rsp_ready = '0;
        bus.req_valid = 4'b0111;
        to_neg();
        check_grant("t5_g0", 4'b0010);
        to_pos();
        to_neg();
        check_grant("t5_g1", 4'b0100);
        to_pos();
        to_neg();
        check_grant("t5_g2", 4'b0001);
        to_pos();
        bus.req_valid = '0;
        to_neg();
        chk("t5_pre_rsp", bus.rsp_valid, 64'b0010);
        chk("t5_pre_busy", bus.busy, 64'b0111);
        do_reset(1);
        for (int c = 0; c < 3; c++) begin
            to_neg();
            chk($sformatf("t5_rsp_c%0d", c), bus.rsp_valid, 64'd0);
            chk($sformatf("t5_busy_c%0d", c), bus.busy, 64'd0);
            chk($sformatf("t5_err_c%0d", c), err_tag, 64'd0);
            to_pos();
        end
        bus.rsp_ready = '1;
        bus.req_valid = 4'b1001;
        to_neg();
        check_grant("t5_rr_zero", 4'b0001);
        to_pos();
        bus.req_valid = '0;
        wait_idle("t5");
        to_neg();
        chk("t5_err_final", err_tag, 64'd0);
        to_pos();

        // tagless LUT output
        inj = 1'b1;
        to_pos();
        inj = 1'b0;
        to_neg();
        chk("t6_err_before", err_tag, 64'd0);
        to_pos();
        for (int c = 0; c < 3; c++) begin
            to_neg();
            chk($sformatf("t6_err_c%0d", c), err_tag, 64'd1);
            chk($sformatf("t6_rsp_c%0d", c), bus.rsp_valid, 64'd0);
            to_pos();
        end
        do_reset(2);
        to_neg();
        chk("t6_err_cleared", err_tag, 64'd0);
        to_pos();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
